// File: rtl/ram_rd_streamer.sv
// Read master for one RAM port: turns a (start address, length) command into a
// burst of sequential reads and re-times the fixed-latency data into a valid/ready stream.
module ram_rd_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] BUF_FULL = CNT_W'(BUF_DEPTH);

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "ram_rd_streamer: RD_LATENCY must be 1 or 2");
  end
  if (BUF_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
    $fatal(1, "ram_rd_streamer: BUF_DEPTH must be at least RD_LATENCY+1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remain;
  logic [CNT_W-1:0]      r_credits;
  logic                  r_done;
  logic                  w_done_nxt;
  logic [RD_LATENCY-1:0] r_tag_vld;
  logic [RD_LATENCY-1:0] r_tag_last;

  logic [DATA_WIDTH-1:0] r_buf_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  r_buf_last;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic w_accept;
  logic w_issue;
  logic w_last_issue;
  logic w_push;
  logic w_pop;
  logic w_final_hs;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign busy     = (r_state != S_IDLE);
  assign ram_en   = busy;
  assign ram_addr = r_addr;
  assign done     = r_done;

  assign out_valid  = (r_count != '0);
  assign out_data   = r_buf_data[r_rd_ptr];
  assign out_last   = r_buf_last[r_rd_ptr] & out_valid;
  assign w_pop      = out_valid & out_ready;
  assign w_final_hs = w_pop & out_last;

  // Tagged read data lands in the buffer in the same cycle the RAM presents it.
  assign w_push       = r_tag_vld[RD_LATENCY-1];
  assign w_last_issue = w_issue && (r_remain == (ADDR_WIDTH+1)'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_accept    = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        // Credits cover every word that could still land in the buffer.
        if (r_credits < BUF_FULL) begin
          w_issue = 1'b1;
          if (r_remain == (ADDR_WIDTH+1)'(1)) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_final_hs) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_remain   <= '0;
      r_credits  <= '0;
      r_done     <= 1'b0;
      r_tag_vld  <= '0;
      r_tag_last <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= w_done_nxt;
      r_tag_vld  <= (r_tag_vld << 1) | RD_LATENCY'(w_issue);
      r_tag_last <= (r_tag_last << 1) | RD_LATENCY'(w_last_issue);
      if (w_accept) begin
        r_addr   <= start_addr;
        r_remain <= len;
      end else if (w_issue) begin
        r_addr   <= r_addr + ADDR_WIDTH'(1);
        r_remain <= r_remain - (ADDR_WIDTH+1)'(1);
      end
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits + CNT_W'(1);
        2'b01:   r_credits <= r_credits - CNT_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_buf_data[i] <= '0;
      r_buf_last <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= ram_rd_data;
        r_buf_last[r_wr_ptr] <= r_tag_last[RD_LATENCY-1];
        r_wr_ptr             <= next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && w_push && !w_pop)
      assert (r_count != BUF_FULL) else $error("ram_rd_streamer: buffer overflow");
  end
`endif

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Directed bench for ram_rd_streamer: a registered-RAM instance for bursts, stalls,
// wrap, zero length, reset abort, plus an unregistered-RAM instance for latency 1.
module tb_ram_rd_streamer;
  localparam int DW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_start, a_busy, a_done, a_ram_en, a_out_valid, a_out_ready, a_out_last;
  logic [AW-1:0] a_start_addr, a_ram_addr;
  logic [AW:0]   a_len;
  logic [DW-1:0] a_rd, a_q1, a_out_data;

  logic          b_start, b_busy, b_done, b_ram_en, b_out_valid, b_out_ready, b_out_last;
  logic [AW-1:0] b_start_addr, b_ram_addr;
  logic [AW:0]   b_len;
  logic [DW-1:0] b_rd, b_out_data;

  int checks = 0;
  int failures = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {24'd0, a} * 32'd3;
  endfunction

  // Registered RAM (two-cycle read) for instance A, plain synchronous RAM for B.
  always @(posedge clk) begin
    if (a_ram_en) begin
      a_q1 <= mem_word(a_ram_addr);
      a_rd <= a_q1;
    end
    if (b_ram_en) b_rd <= mem_word(b_ram_addr);
  end

  ram_rd_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .BUF_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .start_addr(a_start_addr), .len(a_len),
    .busy(a_busy), .done(a_done), .ram_en(a_ram_en), .ram_addr(a_ram_addr),
    .ram_rd_data(a_rd), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_last(a_out_last));

  ram_rd_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .BUF_DEPTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .start_addr(b_start_addr), .len(b_len),
    .busy(b_busy), .done(b_done), .ram_en(b_ram_en), .ram_addr(b_ram_addr),
    .ram_rd_data(b_rd), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [AW-1:0] a, input logic [AW:0] n);
    a_start      = 1'b1;
    a_start_addr = a;
    a_len        = n;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  // Entered at cycle 1 (just after the accepting edge); returns just after the
  // edge that follows the handshake of word number stop_after.
  task automatic collect(input logic [AW-1:0] a, input int n, input bit rnd,
                         input int pulse_cyc, input int stop_after);
    int idx;
    int cyc;
    int first_cyc;
    int last_cyc;
    logic [AW-1:0] ea;
    idx = 0; cyc = 1; first_cyc = 0; last_cyc = 0;
    while (idx < stop_after && cyc < 4000) begin
      a_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == pulse_cyc) begin
        a_start = 1'b1; a_start_addr = 8'h80; a_len = 9'd7;
      end else begin
        a_start = 1'b0;
      end
      @(negedge clk);
      if (cyc == 1) begin
        chk("busy_on", a_busy, 1);
        chk("ram_en_on", a_ram_en, 1);
        chk("done_low", a_done, 0);
      end
      if (!rnd && cyc <= n) begin
        ea = a + AW'(cyc - 1);
        chk("ram_addr", a_ram_addr, ea);
      end
      if (rnd) chk("credits_max", dut_a.r_credits <= 4, 1);
      if (a_out_valid) begin
        if (first_cyc == 0) begin
          first_cyc = cyc;
          chk("first_valid_lat", cyc, 4);
        end
        ea = a + AW'(idx);
        chk("out_data", a_out_data, mem_word(ea));
        chk("out_last", a_out_last, idx == n - 1);
        if (a_out_ready) begin
          idx++;
          last_cyc = cyc;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    a_start = 1'b0;
    chk("words_seen", idx, stop_after);
    if (!rnd && stop_after == n) chk("burst_cycles", last_cyc, n + 3);
  endtask

  task automatic finish_chk();
    @(negedge clk);
    chk("done_pulse", a_done, 1);
    chk("busy_in_done", a_busy, 0);
    chk("valid_after_last", a_out_valid, 0);
  endtask

  initial begin
    int bi, bc, bfirst;
    a_start = 0; a_start_addr = '0; a_len = '0; a_out_ready = 0;
    b_start = 0; b_start_addr = '0; b_len = '0; b_out_ready = 1;
    a_q1 = '0; a_rd = '0; b_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ram_en", a_ram_en, 0);
    chk("rst_ram_addr", a_ram_addr, 0);
    chk("rst_valid", a_out_valid, 0);
    chk("rst_last", a_out_last, 0);
    chk("rst_data", a_out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic burst: 0x30,0x33,0x36,0x39 in cycles 4..7, done in cycle 8
    start_cmd(8'h10, 9'd4);
    collect(8'h10, 4, 1'b0, 0, 4);
    finish_chk();
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_one_cycle", a_done, 0);

    // Random backpressure
    @(posedge clk); #1;
    start_cmd(8'h20, 9'd16);
    collect(8'h20, 16, 1'b1, 0, 16);
    finish_chk();

    // Address wrap FE,FF,00,01
    @(posedge clk); #1;
    start_cmd(8'hFE, 9'd4);
    collect(8'hFE, 4, 1'b0, 0, 4);
    finish_chk();

    // Zero length
    @(posedge clk); #1;
    start_cmd(8'h20, 9'd0);
    @(negedge clk);
    chk("zero_done", a_done, 1);
    chk("zero_busy", a_busy, 0);
    chk("zero_ram_en", a_ram_en, 0);
    chk("zero_valid", a_out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_done_clear", a_done, 0);
    chk("zero_ram_en2", a_ram_en, 0);
    chk("zero_valid2", a_out_valid, 0);

    // Start pulsed mid-burst is ignored
    @(posedge clk); #1;
    start_cmd(8'h40, 9'd6);
    collect(8'h40, 6, 1'b0, 3, 6);
    finish_chk();
    @(posedge clk); #1;
    @(negedge clk);
    chk("ignored_start_idle", a_busy, 0);

    // Full depth, then a start in the done cycle
    @(posedge clk); #1;
    start_cmd(8'h00, 9'd256);
    collect(8'h00, 256, 1'b0, 0, 256);
    finish_chk();
    start_cmd(8'h30, 9'd3);
    collect(8'h30, 3, 1'b0, 0, 3);
    finish_chk();

    // Reset after 5 words
    @(posedge clk); #1;
    start_cmd(8'h50, 9'd16);
    collect(8'h50, 16, 1'b0, 0, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", a_busy, 0);
    chk("arst_done", a_done, 0);
    chk("arst_ram_en", a_ram_en, 0);
    chk("arst_ram_addr", a_ram_addr, 0);
    chk("arst_valid", a_out_valid, 0);
    chk("arst_last", a_out_last, 0);
    chk("arst_data", a_out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid", a_out_valid, 0);
      chk("post_rst_done", a_done, 0);
    end
    @(posedge clk); #1;
    start_cmd(8'h60, 9'd2);
    collect(8'h60, 2, 1'b0, 0, 2);
    finish_chk();

    // Latency-1 instance: first valid in cycle 3
    @(posedge clk); #1;
    b_start = 1'b1; b_start_addr = 8'h05; b_len = 9'd3;
    @(posedge clk); #1;
    b_start = 1'b0;
    bi = 0; bc = 1; bfirst = 0;
    while (bi < 3 && bc < 20) begin
      @(negedge clk);
      if (b_out_valid) begin
        if (bfirst == 0) bfirst = bc;
        chk("b_out_data", b_out_data, mem_word(8'h05 + AW'(bi)));
        chk("b_out_last", b_out_last, bi == 2);
        bi++;
      end
      @(posedge clk); #1;
      bc++;
    end
    chk("b_first_valid", bfirst, 3);
    chk("b_words", bi, 3);
    @(negedge clk);
    chk("b_done", b_done, 1);
    chk("b_busy", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_rd_streamer.md
Name: ram_rd_streamer

Overview:
- Read-side companion for the true-dual-port RAM. It drives one RAM port as a read master and converts the RAM's fixed read latency into a valid/ready stream.
- A command (start address, length) starts a burst of sequential reads. Returned words are buffered under credit-based flow control, so downstream backpressure never loses or duplicates data.
- Sits between the RAM port and any streaming consumer (DMA, packetizer).

Parameters:
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 8, RAM address width; depth = 2**ADDR_WIDTH.
- RD_LATENCY, 2, RAM read latency in cycles:
  - 2 when the RAM registers read data.
  - 1 when it does not.
  - Legal values are 1 and 2; any other value is a $fatal at elaboration.
- BUF_DEPTH, 4, output buffer depth in words:
  - Must be >= RD_LATENCY+1, otherwise $fatal.
  - Full throughput requires >= RD_LATENCY+2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only when busy=0.
- start_addr  in  ADDR_WIDTH  first word address.
- len  in  ADDR_WIDTH+1  words to read, 0..2**ADDR_WIDTH.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer completion.
- ram_en  out  1  RAM port enable (integrator ties that port's wr_en low).
- ram_addr  out  ADDR_WIDTH  RAM port address.
- ram_rd_data  in  DATA_WIDTH  RAM port read data.
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  DATA_WIDTH  stream data.
- out_last  out  1  marks the final word of the transfer.

Behaviour:

Reset and clocking:
- Single clock domain.
- While rst_n=0, all state clears asynchronously:
  - busy=0, done=0, ram_en=0, ram_addr=0, out_valid=0, out_last=0, out_data=0.
  - Buffer is empty and credits are zero.
- Reset mid-transfer aborts the transfer: no further out_valid, no done pulse.

FSM states IDLE, ISSUE, DRAIN:
- IDLE:
  - start=1 with len>0 → load the address counter with start_addr and the remaining count with len; go to ISSUE.
  - start=1 with len=0 → done=1 for the next cycle only, stay IDLE, no RAM reads, no stream output.
- ISSUE: a read is issued in a cycle iff credits < BUF_DEPTH.
  - credits = reads issued but not yet popped from the buffer.
  - Credits are updated from registered state only; there is no combinational out_ready→ram_addr path.
  - On issue: ram_addr = current address; the address increments modulo 2**ADDR_WIDTH (wraps 2**ADDR_WIDTH-1 → 0); the remaining count decrements.
  - Issuing the last word → DRAIN.
- DRAIN:
  - Wait until the final word is handshaken (out_valid & out_ready & out_last).
  - Then → IDLE, with done=1 for exactly one cycle and busy=0 in that same cycle.
  - A new start is accepted in the done cycle.

Busy, start and RAM enable:
- busy=1 from the cycle after start acceptance until the final handshake edge.
- start while busy=1 is ignored; command inputs are not re-sampled.
- ram_en=1 for the whole busy period, because the RAM output register only advances while en=1.

Read-data tracking:
- A valid/last tag pipeline RD_LATENCY deep shadows the RAM.
- Tagged ram_rd_data is written into the FIFO buffer in the cycle it is presented.
- out_last is carried in the buffer alongside the data.

Stream interface:
- out_data/out_valid/out_last come from the buffer head, first-word fall-through, registered.
- Once out_valid is asserted, out_data and out_last are held stable until out_valid & out_ready.
- A pop occurs on out_valid & out_ready and frees one credit on the next cycle.

Latency and throughput:
- Start accepted at edge E0.
- First ram_addr is driven in cycle 1.
- First out_valid occurs in cycle RD_LATENCY+2 (4 at defaults).
- With out_ready held high and BUF_DEPTH >= RD_LATENCY+2, the block sustains one word per cycle.
- Buffer overflow is impossible by construction; a simulation assertion flags it.

Test Plan:
1. Basic burst:
   - Stimulus: RAM preloaded mem[a]=a*3; start_addr=0x10, len=4, out_ready=1.
   - Response: out_valid first 4 cycles after start; data 0x30, 0x33, 0x36, 0x39 on consecutive cycles; out_last only on 0x39; done one cycle later; busy low during done.
2. Backpressure:
   - Stimulus: len=16, out_ready random 50%.
   - Response: all 16 words in order, none dropped or duplicated; data stable while stalled; credits never exceed 4; ram_addr stops advancing while credits=4.
3. Wrap-around:
   - Stimulus: start_addr=0xFE, len=4.
   - Response: ram_addr sequence 0xFE, 0xFF, 0x00, 0x01; matching data out; last on the mem[0x01] word.
4. Zero-length and start while busy:
   - Stimulus: len=0.
   - Response: done the next cycle, no out_valid, ram_en stays 0.
   - Stimulus: start pulsed mid-burst with different addr/len.
   - Response: ignored; the original burst completes unchanged.
5. Full depth and back-to-back:
   - Stimulus: len=256 from addr 0, then a new start in the done cycle.
   - Response: 256 words at one per cycle; second burst first out_valid 4 cycles after its start.
6. Reset mid-transfer and RD_LATENCY=1 variant:
   - Stimulus: rst_n=0 after 5 words.
   - Response: all outputs zero immediately; a subsequent len=2 burst behaves normally.
   - Stimulus: RD_LATENCY=1 with an unregistered RAM.
   - Response: first out_valid 3 cycles after start.
